tt_sweep: RTL and testbench

Sequential truth-table harvester for the 7-input classification netlists. It drives all 128 input minterms into one combinational function block, one per cycle, in ascending order. It samples the block's single output and assembles a 128-bit truth table, then compares that table against an expected signature. It sits directly upstream of the function block, driving `x0..x6`, and directly downstream of it, consuming `out`.

---
 rtl/tt_pkg.sv | 20 ++
 rtl/tt_sweep_if.sv | 32 +++
 rtl/tt_lat_pipe.sv | 42 ++++
 rtl/tt_sweep.sv | 93 +++++++++
 tb/tb_tt_sweep.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table harvester.
// Macro TT_SWEEP_FIRST_FAIL_EN enables the first_fail output.
package tt_pkg;
  localparam int N_IN      = 7;
  localparam int N_MINTERM = 1 << N_IN;

  typedef logic [N_MINTERM-1:0] tt_t;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SWEEP = S_SWEEP,
    ST_DRAIN = S_DRAIN,
    ST_DONE  = S_DONE
  } tt_state_e;
endpackage

// File: rtl/tt_sweep_if.sv
// Harvester bus: sweep control, minterm drive, function sample and results.
// first_fail exists only when TT_SWEEP_FIRST_FAIL_EN is defined.
interface tt_sweep_if;
  import tt_pkg::*;
  logic            start;
  tt_t             expected;
  logic [N_IN-1:0] x;
  logic            f_in;
  logic            busy;
  logic            done;
  tt_t             tt;
  logic            match;
`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic [N_IN-1:0] first_fail;
`endif

  modport master (
    output start, expected, f_in,
    input  x, busy, done, tt, match
`ifdef TT_SWEEP_FIRST_FAIL_EN
    , input first_fail
`endif
  );

  modport slave (
    input  start, expected, f_in,
    output x, busy, done, tt, match
`ifdef TT_SWEEP_FIRST_FAIL_EN
    , output first_fail
`endif
  );
endinterface

// File: rtl/tt_lat_pipe.sv
// (valid, index) delay line matching the function block latency.
// LAT=0 collapses to wires.
module tt_lat_pipe #(
  parameter int LAT = 0,
  parameter int IW  = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [IW-1:0] in_idx,
  output logic          out_vld,
  output logic [IW-1:0] out_idx
);
  generate
    if (LAT == 0) begin : g_wire
      wire unused_ok = &{1'b0, clk, rst};
      assign out_vld = in_vld;
      assign out_idx = in_idx;
    end else begin : g_pipe
      logic [LAT-1:0]         vld_pipe;
      logic [LAT-1:0][IW-1:0] idx_pipe;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe <= '0;
        end else begin
          vld_pipe[0] <= in_vld;
          for (int i = 1; i < LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
      end

      // Index needs no reset: it is only consumed alongside a valid bit.
      always_ff @(posedge clk) begin
        idx_pipe[0] <= in_idx;
        for (int i = 1; i < LAT; i++) idx_pipe[i] <= idx_pipe[i-1];
      end

      assign out_vld = vld_pipe[LAT-1];
      assign out_idx = idx_pipe[LAT-1];
    end
  endgenerate
endmodule

// File: rtl/tt_sweep.sv
// Sweeps all 128 minterms into a 7-input function block, captures its truth
// table and compares it to an expected signature. Optional: TT_SWEEP_FIRST_FAIL_EN.
module tt_sweep
  import tt_pkg::*;
#(
  parameter int FUNC_LAT = 0
) (
  input logic       clk,
  input logic       rst,
  tt_sweep_if.slave bus
);
  logic [1:0]      state;
  logic [N_IN-1:0] cnt;
  tt_t             exp_q, tt_q, tt_nxt;
  logic            match_q;
  logic            active, start_acc, sweep_vld;
  logic            s_vld, last_smp;
  logic [N_IN-1:0] s_idx;

  assign active    = (state == S_SWEEP) || (state == S_DRAIN);
  assign start_acc = (state == S_IDLE) && bus.start;
  assign sweep_vld = (state == S_SWEEP);

  tt_lat_pipe #(.LAT(FUNC_LAT), .IW(N_IN)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (sweep_vld),
    .in_idx  (cnt),
    .out_vld (s_vld),
    .out_idx (s_idx)
  );

  // The sample for minterm 127 is the last one; it marks entry into DONE.
  assign last_smp = s_vld && (&s_idx);

  always_comb begin
    tt_nxt = tt_q;
    if (s_vld) tt_nxt[s_idx] = bus.f_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      exp_q   <= '0;
      tt_q    <= '0;
      match_q <= 1'b0;
    end else begin
      tt_q <= start_acc ? '0 : tt_nxt;
      if (start_acc)     match_q <= 1'b0;
      else if (last_smp) match_q <= (tt_nxt == exp_q);
      case (state)
        S_IDLE: if (bus.start) begin
          state <= S_SWEEP;
          exp_q <= bus.expected;
          cnt   <= '0;
        end
        S_SWEEP: begin
          if (&cnt) state <= last_smp ? S_DONE : S_DRAIN;
          else      cnt   <= cnt + 1'b1;
        end
        S_DRAIN: if (last_smp) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.x     = active ? cnt : '0;
  assign bus.busy  = active;
  assign bus.done  = (state == S_DONE);
  assign bus.tt    = tt_q;
  assign bus.match = match_q;

`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_q;
  logic            ff_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_q    <= '0;
      ff_seen <= 1'b0;
    end else if (start_acc) begin
      ff_q    <= '0;
      ff_seen <= 1'b0;
    end else if (s_vld && !ff_seen && (bus.f_in != exp_q[s_idx])) begin
      ff_q    <= s_idx;
      ff_seen <= 1'b1;
    end
  end

  assign bus.first_fail = ff_q;
`endif
endmodule

// File: tb/tb_tt_sweep.sv
// Bench for tt_sweep: one instance at FUNC_LAT=0 with simple functions, one at
// FUNC_LAT=2 driving a twice-registered majority network.
module tb_tt_sweep;
  import tt_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  bit   sel = 1'b0;
  int   mode = 0;
  logic start_r = 1'b0;
  tt_t  expected_r = '0;

  typedef struct {
    tt_t        tt;
    logic       m;
    logic [6:0] ff;
    int         dc;
  } sb_t;
  sb_t sb[$];

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic ref_f(input int md, input logic [6:0] m);
    logic w0, w1, w2, w3;
    w0 = maj(m[0], m[2], m[3]);
    w1 = maj(m[0], m[3], m[4]);
    w2 = maj(m[4], m[5], m[6]);
    w3 = maj(m[2], w0, w2);
    case (md)
      1:       return m[0];
      2:       return m[6];
      3:       return maj(m[1], w1, w3);
      default: return 1'b0;
    endcase
  endfunction

  tt_sweep_if if0 ();
  tt_sweep_if if2 ();

  assign if0.start    = sel ? 1'b0 : start_r;
  assign if2.start    = sel ? start_r : 1'b0;
  assign if0.expected = expected_r;
  assign if2.expected = expected_r;
  assign if0.f_in     = ref_f(mode, if0.x);

  logic r1, r2;
  always @(posedge clk) begin
    r1 <= ref_f(3, if2.x);
    r2 <= r1;
  end
  assign if2.f_in = r2;

  tt_sweep #(.FUNC_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  tt_sweep #(.FUNC_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  logic       m_done, m_busy, m_match;
  logic [6:0] m_x;
  tt_t        m_tt;
  assign m_done  = sel ? if2.done  : if0.done;
  assign m_busy  = sel ? if2.busy  : if0.busy;
  assign m_match = sel ? if2.match : if0.match;
  assign m_x     = sel ? if2.x     : if0.x;
  assign m_tt    = sel ? if2.tt    : if0.tt;
`ifdef TT_SWEEP_FIRST_FAIL_EN
  logic [6:0] m_ff;
  assign m_ff = sel ? if2.first_fail : if0.first_fail;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, m_x, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_tt"}, m_tt, 0);
    chk({tag, "_match"}, m_match, 0);
`ifdef TT_SWEEP_FIRST_FAIL_EN
    chk({tag, "_ff"}, m_ff, 0);
`endif
  endtask

  // Called at a negedge; returns at the negedge of the cycle after done.
  task automatic sweep(input string tag, input bit s, input int md, input tt_t ex,
                       input tt_t exp_tt, input logic exp_m, input logic [6:0] exp_ff,
                       input bit pulse);
    sb_t it;
    int  s0, cn;
    bit  got, x_ok;
    sel = s;
    mode = md;
    it.tt = exp_tt; it.m = exp_m; it.ff = exp_ff; it.dc = s ? 131 : 129;
    sb.push_back(it);
    start_r = 1'b1;
    expected_r = ex;
    @(negedge clk);
    start_r = 1'b0;
    s0 = cyc;
    chk({tag, "_busy_c1"}, m_busy, 1);
    got = 1'b0;
    x_ok = 1'b1;
    cn = 0;
    for (int k = 0; k < 400 && !got; k++) begin
      cn = cyc - s0 + 1;
      if (m_done) begin
        got = 1'b1;
      end else begin
        if (cn <= 128 && m_x !== 7'(cn - 1)) x_ok = 1'b0;
        start_r = pulse && (cn == 10 || cn == 60);
        @(negedge clk);
      end
    end
    start_r = 1'b0;
    chk({tag, "_x_seq"}, x_ok, 1);
    chk({tag, "_timeout"}, got, 1);
    it = sb.pop_front();
    if (got) begin
      chk({tag, "_done_cyc"}, cn, it.dc);
      chk({tag, "_busy_done"}, m_busy, 0);
      chk({tag, "_tt"}, m_tt, it.tt);
      chk({tag, "_match"}, m_match, it.m);
`ifdef TT_SWEEP_FIRST_FAIL_EN
      chk({tag, "_ff"}, m_ff, it.ff);
`endif
      start_r = pulse;
      @(negedge clk);
      start_r = 1'b0;
      chk({tag, "_done_pulse"}, m_done, 0);
      chk({tag, "_idle_after"}, m_busy, 0);
      chk({tag, "_hold_tt"}, m_tt, it.tt);
    end
  endtask

  localparam tt_t TT_X0  = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam tt_t TT_X6  = {{64{1'b1}}, {64{1'b0}}};
  localparam tt_t TT_MAJ = 128'hfee8eac0fee8e880fee8e880fca8e880;

  initial begin
    tt_t bad;
    bad = TT_MAJ;
    bad[5]  = ~bad[5];
    bad[90] = ~bad[90];

    repeat (3) @(negedge clk);
    sel = 1'b0; chk_idle("rst0");
    sel = 1'b1; chk_idle("rst2");
    rst = 1'b0;
    @(negedge clk);

    sweep("const0", 1'b0, 0, '0,    '0,     1'b1, 7'd0, 1'b0);
    sweep("x0",     1'b0, 1, TT_X0, TT_X0,  1'b1, 7'd0, 1'b0);
    sweep("x6",     1'b0, 2, TT_X6, TT_X6,  1'b1, 7'd0, 1'b0);
    sweep("x0bad",  1'b0, 1, '0,    TT_X0,  1'b0, 7'd1, 1'b0);
    sweep("maj",    1'b1, 3, TT_MAJ, TT_MAJ, 1'b1, 7'd0, 1'b0);
    sweep("majbad", 1'b1, 3, bad,    TT_MAJ, 1'b0, 7'd5, 1'b0);
    sweep("busy_st", 1'b0, 1, TT_X0, TT_X0, 1'b1, 7'd0, 1'b1);

    // Reset sampled at the end of cycle 50 of a sweep.
    sel = 1'b0;
    mode = 1;
    start_r = 1'b1;
    expected_r = TT_X0;
    @(negedge clk);
    start_r = 1'b0;
    repeat (49) @(negedge clk);
    chk("mid_busy", m_busy, 1);
    chk("mid_x", m_x, 49);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("mid_rst");
    begin
      bit saw_done = 1'b0;
      for (int k = 0; k < 150; k++) begin
        if (m_done || m_busy) saw_done = 1'b1;
        @(negedge clk);
      end
      chk("mid_no_done", saw_done, 0);
    end

    sweep("after_rst", 1'b0, 2, TT_X6, TT_X6, 1'b1, 7'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
